// File: rtl/load_store_unit.sv
// RV32I load/store unit: handles sub-word and misaligned accesses by
// splitting them into up to two aligned word transfers on the memory port.
module load_store_unit #(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        clk_dm,
    input  logic        rst_dm,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        ACC0,
        ACC1,
        RESP
    } state_t;

    state_t      state_q, state_d;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] lo_q;
    logic [31:0] hi_q;
    logic        err_q;
    logic [7:0]  wcnt_q;

    logic [1:0]  off;
    logic [4:0]  sh;
    logic [3:0]  size_mask;
    logic [7:0]  lane8;
    logic [63:0] wide_w;
    logic [31:0] rd_word;
    logic [31:0] ext;
    logic        legal_in;
    logic        timeout;

    assign off     = addr_q[1:0];
    assign sh      = {off, 3'b000};
    assign lane8   = {4'b0000, size_mask} << off;
    assign wide_w  = {32'h0, wdata_q} << sh;
    assign rd_word = 32'({hi_q, lo_q} >> sh);
    assign timeout = (wcnt_q == 8'(MAX_WAIT - 1));

    // Size mask from the funct3 width field
    always_comb begin
        size_mask = 4'b1111;
        unique case (f3_q[1:0])
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
    end

    // Legality of the incoming request; stores have no unsigned forms
    always_comb begin
        legal_in = 1'b0;
        unique case (req_funct3)
            3'b000, 3'b001, 3'b010: legal_in = 1'b1;
            3'b100, 3'b101:         legal_in = ~req_we;
            default:                legal_in = 1'b0;
        endcase
    end

    // Truncate the shifted read word to size and sign/zero extend
    always_comb begin
        ext = rd_word;
        unique case (f3_q[1:0])
            2'b00:   ext = {{24{~f3_q[2] & rd_word[7]}}, rd_word[7:0]};
            2'b01:   ext = {{16{~f3_q[2] & rd_word[15]}}, rd_word[15:0]};
            default: ext = rd_word;
        endcase
    end

    // Next-state logic and all port outputs
    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = 32'h0;
        resp_err   = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = 32'h0;
        mem_be     = 4'h0;
        mem_wdata  = 32'h0;
        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_d = legal_in ? ACC0 : RESP;
                end
            end
            ACC0: begin
                mem_req   = 1'b1;
                mem_we    = we_q;
                mem_addr  = {addr_q[31:2], 2'b00};
                mem_be    = lane8[3:0];
                mem_wdata = wide_w[31:0];
                if (mem_ack) begin
                    state_d = (|lane8[7:4]) ? ACC1 : RESP;
                end else if (timeout) begin
                    state_d = RESP;
                end
            end
            ACC1: begin
                mem_req   = 1'b1;
                mem_we    = we_q;
                mem_addr  = {addr_q[31:2] + 30'd1, 2'b00};
                mem_be    = lane8[7:4];
                mem_wdata = wide_w[63:32];
                if (mem_ack || timeout) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                resp_rdata = (err_q || we_q) ? 32'h0 : ext;
                state_d    = IDLE;
            end
        endcase
    end

    // State, request latch, read capture and wait counter
    always_ff @(posedge clk_dm or negedge rst_dm) begin
        if (!rst_dm) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            lo_q    <= 32'h0;
            hi_q    <= 32'h0;
            err_q   <= 1'b0;
            wcnt_q  <= 8'h0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        f3_q    <= req_funct3;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        lo_q    <= 32'h0;
                        hi_q    <= 32'h0;
                        err_q   <= ~legal_in;
                        wcnt_q  <= 8'h0;
                    end
                end
                ACC0, ACC1: begin
                    if (mem_ack) begin
                        if (state_q == ACC0) begin
                            lo_q <= mem_rdata;
                        end else begin
                            hi_q <= mem_rdata;
                        end
                        wcnt_q <= 8'h0;
                    end else if (timeout) begin
                        err_q  <= 1'b1;
                        wcnt_q <= 8'h0;
                    end else begin
                        wcnt_q <= wcnt_q + 8'd1;
                    end
                end
                RESP: begin
                    wcnt_q <= 8'h0;
                end
            endcase
        end
    end

endmodule
